// File: rtl/microseq_pkg.sv
// Shared types and constants for the microsequencer.
package microseq_pkg;

  localparam int STATE_W     = 7;
  localparam int FETCH_STATE = 1;

  // Next-state action field carried in every microstore word
  typedef enum logic [2:0] {
    ENCODE = 3'b000,
    FETCH  = 3'b001,
    INCR   = 3'b010,
    CJUMP  = 3'b011,
    CWAIT  = 3'b100,
    JUMP   = 3'b101,
    CALL   = 3'b110,
    RETURN = 3'b111
  } ns_sel_t;

  // Source of the branch/wait condition
  typedef enum logic [1:0] {
    SEL_MOC  = 2'b00,
    SEL_COND = 2'b01,
    SEL_INTR = 2'b10,
    SEL_ONE  = 2'b11
  } cond_sel_t;

endpackage

// File: rtl/microseq_cond_mux.sv
// Condition selector: picks one condition source and optionally inverts it.
module microseq_cond_mux
  import microseq_pkg::*;
(
  input  logic       [1:0] condSel,
  input  logic             invert,
  input  logic             moc,
  input  logic             cond,
  input  logic             intr,
  output logic             c
);

  logic selected;

  // Purely combinational select; result is used in the same cycle
  always_comb begin
    selected = 1'b1;
    unique case (cond_sel_t'(condSel))
      SEL_MOC:  selected = moc;
      SEL_COND: selected = cond;
      SEL_INTR: selected = intr;
      SEL_ONE:  selected = 1'b1;
      default:  selected = 1'b1;
    endcase
  end

  assign c = selected ^ invert;

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: registered control-state number with a single-level
// subroutine return register. Optional CWAIT watchdog is enabled by
// defining MICROSEQ_TIMEOUT_EN.
module microsequencer #(
  parameter int STATE_W       = microseq_pkg::STATE_W,
  parameter int TIMEOUT_LIMIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         nsSel,
  input  logic [1:0]         condSel,
  input  logic               invert,
  input  logic               moc,
  input  logic               cond,
  input  logic               intr,
  input  logic [STATE_W-1:0] crAddr,
  input  logic [STATE_W-1:0] encState,
  output logic [STATE_W-1:0] currentState,
  output logic               timeout
);

  import microseq_pkg::*;

  logic               c;
  logic [STATE_W-1:0] state_next;
  logic [STATE_W-1:0] state_plus1;
  logic [STATE_W-1:0] ret_reg;
  logic [STATE_W-1:0] ret_next;

  microseq_cond_mux u_cond_mux (
    .condSel (condSel),
    .invert  (invert),
    .moc     (moc),
    .cond    (cond),
    .intr    (intr),
    .c       (c)
  );

  // Wraps modulo 2^STATE_W by truncation
  assign state_plus1 = currentState + STATE_W'(1);

`ifdef MICROSEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_LIMIT < 1) ? 1 : $clog2(TIMEOUT_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             timeout_next;
`endif

  // Next-state selection; CALL is the only action that loads the return register
  always_comb begin
    state_next = currentState;
    ret_next   = ret_reg;
`ifdef MICROSEQ_TIMEOUT_EN
    wait_cnt_next = '0;
    timeout_next  = 1'b0;
`endif
    unique case (ns_sel_t'(nsSel))
      ENCODE: state_next = encState;
      FETCH:  state_next = STATE_W'(FETCH_STATE);
      INCR:   state_next = state_plus1;
      CJUMP:  state_next = c ? crAddr : state_plus1;
      CWAIT: begin
        if (c) begin
          state_next = state_plus1;
        end else begin
`ifdef MICROSEQ_TIMEOUT_EN
          // Watchdog: a satisfied condition on the limit cycle still wins
          if (wait_cnt_reg == CNT_W'(TIMEOUT_LIMIT)) begin
            state_next   = '0;
            timeout_next = 1'b1;
          end else begin
            state_next    = currentState;
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          end
`else
          state_next = currentState;
`endif
        end
      end
      JUMP:   state_next = crAddr;
      CALL: begin
        state_next = crAddr;
        ret_next   = state_plus1;
      end
      RETURN: state_next = ret_reg;
      default: state_next = currentState;
    endcase
  end

  // State and return register; reset overrides every action
  always_ff @(posedge clk) begin
    if (reset) begin
      currentState <= '0;
      ret_reg      <= '0;
    end else begin
      currentState <= state_next;
      ret_reg      <= ret_next;
    end
  end

`ifdef MICROSEQ_TIMEOUT_EN
  // Wait counter and timeout pulse, registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
      timeout      <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      timeout      <= timeout_next;
    end
  end
`else
  // Constant 0; the expression keeps TIMEOUT_LIMIT referenced in this build
  assign timeout = (TIMEOUT_LIMIT < 0);
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: stimulus pushes expected
// state/timeout per cycle, a monitor pops and compares after each edge.
module tb_microsequencer;
  import microseq_pkg::*;

`ifdef MICROSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [2:0] nsSel;
  logic [1:0] condSel;
  logic       invert;
  logic       moc;
  logic       cond;
  logic       intr;
  logic [6:0] crAddr;
  logic [6:0] encState;
  logic [6:0] currentState;
  logic       timeout;

  typedef struct {
    string      name;
    logic [6:0] st;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  microsequencer #(.STATE_W(7), .TIMEOUT_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .nsSel        (nsSel),
    .condSel      (condSel),
    .invert       (invert),
    .moc          (moc),
    .cond         (cond),
    .intr         (intr),
    .crAddr       (crAddr),
    .encState     (encState),
    .currentState (currentState),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the expected registered result
  task automatic drive(input string name, input logic r, input logic [2:0] ns,
                       input logic [1:0] cs, input logic inv, input logic m,
                       input logic cd, input logic it, input logic [6:0] cr,
                       input logic [6:0] enc, input logic [6:0] exp_s,
                       input logic exp_to);
    exp_t e;
    @(negedge clk);
    reset = r; nsSel = ns; condSel = cs; invert = inv;
    moc = m; cond = cd; intr = it; crAddr = cr; encState = enc;
    e.name = name; e.st = exp_s; e.to = exp_to;
    sb_q.push_back(e);
  endtask

  // Monitor: compares after every rising edge that has a pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (currentState !== e.st || timeout !== e.to) begin
          miscompares++;
          $display("FAIL %s: got state=%0d timeout=%b, expected state=%0d timeout=%b",
                   e.name, currentState, timeout, e.st, e.to);
        end else begin
          $display("ok   %s: state=%0d timeout=%b", e.name, currentState, timeout);
        end
      end
    end
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; nsSel = '0; condSel = '0; invert = 1'b0;
    moc = 1'b0; cond = 1'b0; intr = 1'b0; crAddr = '0; encState = '0;

    // V1: reset with arbitrary inputs
    drive("v1_rst_a", 1, JUMP, 2'd3, 0, 1, 1, 1, 7'd55, 7'd77, 7'd0, 0);
    drive("v1_rst_b", 1, CALL, 2'd1, 1, 0, 1, 0, 7'd33, 7'd12, 7'd0, 0);
    drive("ret_noprior", 0, RETURN, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd0, 0);

    // V2: fetch, encode, increment
    drive("v2_fetch", 0, FETCH, 2'd0, 0, 0, 0, 0, 7'd90, 7'd0, 7'd1, 0);
    drive("v2_encode", 0, ENCODE, 2'd0, 0, 0, 0, 0, 7'd90, 7'd7, 7'd7, 0);
    drive("v2_incr", 0, INCR, 2'd0, 0, 0, 0, 0, 7'd90, 7'd7, 7'd8, 0);
    drive("v2_incr9", 0, INCR, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd9, 0);

    // V3: CWAIT on moc, then inverted
    for (int i = 0; i < 4; i++)
      drive("v3_hold", 0, CWAIT, 2'd0, 0, 0, 1, 1, 7'd0, 7'd0, 7'd9, 0);
    drive("v3_adv", 0, CWAIT, 2'd0, 0, 1, 0, 0, 7'd0, 7'd0, 7'd10, 0);
    drive("v3_inv_adv_a", 0, CWAIT, 2'd0, 1, 0, 0, 0, 7'd0, 7'd0, 7'd11, 0);
    drive("v3_inv_adv_b", 0, CWAIT, 2'd0, 1, 0, 0, 0, 7'd0, 7'd0, 7'd12, 0);
    drive("v3_inv_hold", 0, CWAIT, 2'd0, 1, 1, 0, 0, 7'd0, 7'd0, 7'd12, 0);

    // V4: call/return and wrap
    drive("v4_call", 0, CALL, 2'd0, 0, 0, 0, 0, 7'd16, 7'd0, 7'd16, 0);
    drive("v4_return", 0, RETURN, 2'd0, 0, 0, 0, 0, 7'd99, 7'd0, 7'd13, 0);
    drive("v4_jump126", 0, JUMP, 2'd0, 0, 0, 0, 0, 7'd126, 7'd0, 7'd126, 0);
    drive("v4_call126", 0, CALL, 2'd0, 0, 0, 0, 0, 7'd5, 7'd0, 7'd5, 0);
    drive("v4_ret127", 0, RETURN, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd127, 0);
    drive("v4_wrap", 0, INCR, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd0, 0);

    // Conditional jump across all condition sources
    drive("cj_one", 0, CJUMP, 2'd3, 0, 0, 0, 0, 7'd40, 7'd0, 7'd40, 0);
    drive("cj_cond0", 0, CJUMP, 2'd1, 0, 1, 0, 1, 7'd99, 7'd0, 7'd41, 0);
    drive("cj_intr_inv", 0, CJUMP, 2'd2, 1, 1, 1, 1, 7'd99, 7'd0, 7'd42, 0);
    drive("cj_cond1", 0, CJUMP, 2'd1, 0, 0, 1, 0, 7'd20, 7'd0, 7'd20, 0);
    drive("enc_127", 0, ENCODE, 2'd0, 0, 0, 0, 0, 7'd0, 7'd127, 7'd127, 0);

    // V5: watchdog expiry (holds indefinitely when the watchdog is absent)
    drive("v5_jump9", 0, JUMP, 2'd0, 0, 0, 0, 0, 7'd9, 7'd0, 7'd9, 0);
    for (int i = 0; i < 4; i++)
      drive("v5_hold", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd9, 0);
    drive("v5_limit", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, TO_EN ? 7'd0 : 7'd9, TO_EN);
    drive("v5_after", 0, INCR, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, TO_EN ? 7'd1 : 7'd10, 0);
    drive("v5b_jump9", 0, JUMP, 2'd0, 0, 0, 0, 0, 7'd9, 7'd0, 7'd9, 0);
    for (int i = 0; i < 4; i++)
      drive("v5b_hold", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd9, 0);
    drive("v5b_c_wins", 0, CWAIT, 2'd0, 0, 1, 0, 0, 7'd0, 7'd0, 7'd10, 0);
    drive("v5b_hold10", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd10, 0);

    // V6: reset mid-CWAIT clears the counter; reset in a CALL discards it
    drive("v6_jump30", 0, JUMP, 2'd0, 0, 0, 0, 0, 7'd30, 7'd0, 7'd30, 0);
    for (int i = 0; i < 3; i++)
      drive("v6_hold", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd30, 0);
    drive("v6_rst_wait", 1, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd0, 0);
    drive("v6_jump30b", 0, JUMP, 2'd0, 0, 0, 0, 0, 7'd30, 7'd0, 7'd30, 0);
    for (int i = 0; i < 4; i++)
      drive("v6_hold_fresh", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd30, 0);
    drive("v6_limit", 0, CWAIT, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, TO_EN ? 7'd0 : 7'd30, TO_EN);
    drive("v6_jump50", 0, JUMP, 2'd0, 0, 0, 0, 0, 7'd50, 7'd0, 7'd50, 0);
    drive("v6_rst_call", 1, CALL, 2'd0, 0, 0, 0, 0, 7'd60, 7'd0, 7'd0, 0);
    drive("v6_return", 0, RETURN, 2'd0, 0, 0, 0, 0, 7'd0, 7'd0, 7'd0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
